// File: rtl/rom_seq_pkg.sv
// Shared definitions for rom_seq_ctrl: opcodes, ALU op codes, instruction field
// positions, FSM state encoding and the combinational opcode decoder.
package rom_seq_pkg;

  localparam int unsigned OPC_HI = 8;
  localparam int unsigned OPC_LO = 6;
  localparam int unsigned RD_HI  = 5;
  localparam int unsigned RD_LO  = 3;
  localparam int unsigned RS_HI  = 2;
  localparam int unsigned RS_LO  = 0;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b100;

  localparam logic [1:0] ALU_OP_PASS = 2'b00;
  localparam logic [1:0] ALU_OP_ADD  = 2'b01;
  localparam logic [1:0] ALU_OP_XOR  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_AWAIT,
    ST_WB,
    ST_ADV,
    ST_SETTLE,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       to_wb;
    logic       to_exec;
    logic       illegal;
    logic       imm_sel;
    logic [1:0] alu_op;
  } dec_t;

  // Neither to_wb nor to_exec means the sequencer stops (HALT or illegal).
  function automatic dec_t decode_op(input logic [2:0] op);
    dec_t d;
    d        = '0;
    d.alu_op = ALU_OP_PASS;
    case (op)
      OP_LOAD: begin
        d.to_wb   = 1'b1;
        d.imm_sel = 1'b1;
      end
      OP_MOVE: d.to_wb = 1'b1;
      OP_ADD: begin
        d.to_exec = 1'b1;
        d.alu_op  = ALU_OP_ADD;
      end
      OP_XOR: begin
        d.to_exec = 1'b1;
        d.alu_op  = ALU_OP_XOR;
      end
      OP_HALT: d.illegal = 1'b0;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rom_seq_ctrl.sv
// Multi-cycle sequencer for the 9-bit instruction / 16-bit immediate program store.
// Optional ALU watchdog enabled by defining ROM_SEQ_ALU_TIMEOUT_EN.
module rom_seq_ctrl
  import rom_seq_pkg::*;
#(
  parameter int unsigned IW          = 9,
  parameter int unsigned DW          = 16,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [IW-1:0]    instruction,
  input  logic [DW-1:0]    data_var,
  output logic             step,
  output logic [2:0]       rd_sel,
  output logic [2:0]       rs_sel,
  output logic [DW-1:0]    imm_out,
  output logic             imm_sel,
  output logic [1:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             reg_we,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  if (ALU_TIMEOUT == 0) begin : g_bad_timeout
    $error("rom_seq_ctrl: ALU_TIMEOUT must be nonzero");
  end

  state_t           r_state;
  logic [2:0]       r_ir_op;
  logic [DW-1:0]    r_imm;
  logic [2:0]       r_rd_sel;
  logic [2:0]       r_rs_sel;
  logic [1:0]       r_alu_op;
  logic             r_step;
  logic             r_alu_start;
  logic             r_reg_we;
  logic             r_imm_sel;
  logic             r_busy;
  logic             r_done;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  dec_t             w_dec;

`ifdef ROM_SEQ_ALU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ALU_TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
`endif

  assign w_dec = decode_op(r_ir_op);

  // Outputs are registered: each is asserted during the cycle spent in its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ir_op     <= '0;
      r_imm       <= '0;
      r_rd_sel    <= '0;
      r_rs_sel    <= '0;
      r_alu_op    <= '0;
      r_step      <= 1'b0;
      r_alu_start <= 1'b0;
      r_reg_we    <= 1'b0;
      r_imm_sel   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
      r_retired   <= '0;
`ifdef ROM_SEQ_ALU_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      r_step      <= 1'b0;
      r_alu_start <= 1'b0;
      r_reg_we    <= 1'b0;
      r_imm_sel   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_ir_op  <= instruction[OPC_HI:OPC_LO];
          r_rd_sel <= instruction[RD_HI:RD_LO];
          r_rs_sel <= instruction[RS_HI:RS_LO];
          r_imm    <= data_var;
          r_state  <= ST_DECODE;
        end
        ST_DECODE: begin
          r_alu_op <= w_dec.alu_op;
          if (w_dec.to_wb) begin
            r_state   <= ST_WB;
            r_reg_we  <= 1'b1;
            r_imm_sel <= w_dec.imm_sel;
          end else if (w_dec.to_exec) begin
            r_state     <= ST_EXEC;
            r_alu_start <= 1'b1;
          end else begin
            r_state   <= ST_HALT;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_illegal <= r_illegal | w_dec.illegal;
          end
        end
        ST_EXEC: begin
          r_state <= ST_AWAIT;
`ifdef ROM_SEQ_ALU_TIMEOUT_EN
          r_tmo   <= TW'(ALU_TIMEOUT);
`endif
        end
        ST_AWAIT: begin
          if (alu_done) begin
            r_state  <= ST_WB;
            r_reg_we <= 1'b1;
          end
`ifdef ROM_SEQ_ALU_TIMEOUT_EN
          else if (r_tmo <= TW'(1)) begin
            r_state   <= ST_HALT;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_illegal <= 1'b1;
            r_tmo     <= '0;
          end else begin
            r_tmo <= r_tmo - TW'(1);
          end
`endif
        end
        ST_WB: begin
          r_retired <= r_retired + CNT_W'(1);
          r_step    <= 1'b1;
          r_state   <= ST_ADV;
        end
        ST_ADV:    r_state <= ST_SETTLE;
        ST_SETTLE: r_state <= ST_FETCH;
        ST_HALT:   r_state <= ST_HALT;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign step      = r_step;
  assign rd_sel    = r_rd_sel;
  assign rs_sel    = r_rs_sel;
  assign imm_out   = r_imm;
  assign imm_sel   = r_imm_sel;
  assign alu_op    = r_alu_op;
  assign alu_start = r_alu_start;
  assign reg_we    = r_reg_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign illegal   = r_illegal;
  assign retired   = r_retired;

endmodule

// File: tb/tb_rom_seq_ctrl.sv
// Bench for rom_seq_ctrl: program-store and ALU responders plus a per-cycle trace
// model built from the instruction-level timing rules.
module tb_rom_seq_ctrl;

  localparam int unsigned IW = 9, DW = 16, CNT_W = 8, ALU_TIMEOUT = 16, PMAX = 512;

  logic clk = 1'b0;
  logic rst_n, run, alu_done;
  logic [IW-1:0] instruction;
  logic [DW-1:0] data_var, imm_out;
  logic step, alu_start, reg_we, imm_sel, busy, done, illegal;
  logic [2:0] rd_sel, rs_sel;
  logic [1:0] alu_op;
  logic [CNT_W-1:0] retired;

  rom_seq_ctrl #(.IW(IW), .DW(DW), .CNT_W(CNT_W), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction), .data_var(data_var),
    .step(step), .rd_sel(rd_sel), .rs_sel(rs_sel), .imm_out(imm_out), .imm_sel(imm_sel),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done), .reg_we(reg_we),
    .busy(busy), .done(done), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // Program store: per-address instruction, immediate, ALU latency (0 = never) and
  // whether alu_done is also raised (to be ignored) during the EXEC cycle.
  logic [IW-1:0] p_ins [PMAX];
  logic [DW-1:0] p_dat [PMAX];
  int unsigned   p_dly [PMAX];
  bit            p_sp  [PMAX];
  int unsigned   addr = 0;

  assign instruction = p_ins[addr % PMAX];
  assign data_var    = p_dat[addr % PMAX];
  always @(posedge clk) if (!rst_n) addr <= 0; else if (step) addr <= addr + 1;

  initial begin
    alu_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst_n && alu_start) begin
        int unsigned d;
        d = p_dly[addr % PMAX];
        alu_done = p_sp[addr % PMAX];
        for (int unsigned i = 1; i <= d; i++) begin
          @(posedge clk); #2;
          if (!rst_n) break;
          alu_done = (i == d);
        end
        @(posedge clk); #2;
        alu_done = 1'b0;
      end
    end
  end

  typedef struct {
    bit step, we, start, isel, busy, done, ill, chk_sel, chk_op;
    int unsigned ret;
    logic [2:0] rd, rs;
    logic [DW-1:0] imm;
    logic [1:0] aop;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  int errors = 0, checks = 0;
  int n_we, n_step, n_start, cyc, we_cyc;
  logic [2:0] we_rd[$];
  logic [DW-1:0] we_imm;
  logic we_isel;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(int unsigned ret, bit bsy);
    exp_t e;
    e.step = 0; e.we = 0; e.start = 0; e.isel = 0; e.busy = bsy; e.done = 0; e.ill = 0;
    e.chk_sel = 0; e.chk_op = 0; e.ret = ret; e.rd = '0; e.rs = '0; e.imm = '0; e.aop = '0;
    return e;
  endfunction

  // Expand the program into the cycle-by-cycle output trace, starting with the IDLE
  // cycle in which run is sampled. Each instruction: FETCH, DECODE, then either
  // write-back (LOAD/MOVE), EXEC + N AWAIT + write-back (ADD/XOR), or stop.
  task automatic model_program();
    exp_t e;
    int unsigned pc = 0, ret = 0;
    logic [2:0] op;
    q.push_back(mk(0, 0));
    while (1) begin
      op = p_ins[pc % PMAX][8:6];
      q.push_back(mk(ret, 1));
      e = mk(ret, 1);
      e.chk_sel = 1; e.rd = p_ins[pc % PMAX][5:3]; e.rs = p_ins[pc % PMAX][2:0];
      e.imm = p_dat[pc % PMAX];
      q.push_back(e);
      if (op >= 3'd4) begin
        e.busy = 0; e.done = 1; e.ill = (op != 3'd4);
        repeat (4) q.push_back(e);
        break;
      end
      if (op >= 3'd2) begin
        e.start = 1; e.chk_op = 1; e.aop = (op == 3'd2) ? 2'b01 : 2'b10;
        q.push_back(e);
        e.start = 0;
        if (p_dly[pc % PMAX] == 0) begin
          repeat (ALU_TIMEOUT) q.push_back(e);
          e.busy = 0; e.done = 1; e.ill = 1;
          repeat (4) q.push_back(e);
          break;
        end
        repeat (p_dly[pc % PMAX]) q.push_back(e);
      end
      e.we = 1; e.isel = (op == 3'd0);
      q.push_back(e);
      e.we = 0; e.isel = 0;
      ret = (ret + 1) % 256;
      e.ret = ret; e.step = 1;
      q.push_back(e);
      e.step = 0;
      q.push_back(e);
      pc++;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      ce = q.pop_front();
      chk("step", 32'(step), 32'(ce.step));
      chk("reg_we", 32'(reg_we), 32'(ce.we));
      chk("alu_start", 32'(alu_start), 32'(ce.start));
      chk("imm_sel", 32'(imm_sel), 32'(ce.isel));
      chk("busy", 32'(busy), 32'(ce.busy));
      chk("done", 32'(done), 32'(ce.done));
      chk("illegal", 32'(illegal), 32'(ce.ill));
      chk("retired", 32'(retired), ce.ret);
      if (ce.chk_sel) begin
        chk("rd_sel", 32'(rd_sel), 32'(ce.rd));
        chk("rs_sel", 32'(rs_sel), 32'(ce.rs));
        chk("imm_out", 32'(imm_out), 32'(ce.imm));
      end
      if (ce.chk_op) chk("alu_op", 32'(alu_op), 32'(ce.aop));
      if (reg_we) begin
        n_we++;
        we_rd.push_back(rd_sel);
        if (we_cyc < 0) we_cyc = cyc;
        we_imm  = imm_out;
        we_isel = imm_sel;
      end
      if (step) n_step++;
      if (alu_start) n_start++;
      cyc++;
    end
  end

  function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {op, rd, rs};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < int'(PMAX); i++) begin
      p_ins[i] = '0; p_dat[i] = '0; p_dly[i] = 1; p_sp[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic check_idle_zero(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_reg_we"}, 32'(reg_we), 32'd0);
    chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_rd_sel"}, 32'(rd_sel), 32'd0);
    chk({tag, "_imm_out"}, 32'(imm_out), 32'd0);
  endtask

  // Called at posedge+1 with the DUT in IDLE; run is random after the first cycle.
  task automatic start_prog();
    n_we = 0; n_step = 0; n_start = 0; cyc = 0; we_cyc = -1; we_rd.delete();
    model_program();
    run = 1'b1;
  endtask

  task automatic run_prog(input int unsigned bound);
    start_prog();
    for (int unsigned c = 0; c < bound && q.size() > 0; c++) begin
      @(posedge clk); #1;
      run = 1'($urandom_range(0, 1));
    end
    if (q.size() > 0) begin
      chk("trace_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    int exp_rd[5];
    exp_rd = '{0, 1, 2, 1, 2};
    clear_prog();
    do_reset();
    check_idle_zero("reset");
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_run0_busy", 32'(busy), 32'd0);

    // Reference program: LOAD r0,9; MOVE r1,r0; MOVE r2,r0; ADD r1,r0; XOR r2,r1; HALT
    p_ins[0] = ins(3'd0, 3'd0, 3'd0); p_dat[0] = 16'd9;
    p_ins[1] = ins(3'd1, 3'd1, 3'd0);
    p_ins[2] = ins(3'd1, 3'd2, 3'd0);
    p_ins[3] = ins(3'd2, 3'd1, 3'd0);
    p_ins[4] = ins(3'd3, 3'd2, 3'd1);
    p_ins[5] = ins(3'd4, 3'd0, 3'd0);
    run_prog(300);
    chk("prog_we_count", 32'(n_we), 32'd5);
    chk("prog_step_count", 32'(n_step), 32'd5);
    chk("prog_retired", 32'(retired), 32'd5);
    chk("prog_done", 32'(done), 32'd1);
    chk("prog_illegal", 32'(illegal), 32'd0);
    chk("prog_we_log_len", 32'(we_rd.size()), 32'd5);
    for (int i = 0; i < 5 && i < we_rd.size(); i++) chk("prog_we_rd", 32'(we_rd[i]), 32'(exp_rd[i]));

    // LOAD r3,0xBEEF: WB is the 4th cycle counting the IDLE cycle that sampled run
    do_reset(); clear_prog();
    p_ins[0] = ins(3'd0, 3'd3, 3'd6); p_dat[0] = 16'hBEEF;
    p_ins[1] = ins(3'd4, 3'd0, 3'd0);
    run_prog(100);
    chk("load_we_cycle", 32'(we_cyc), 32'd3);
    chk("load_rd", 32'(we_rd.size() > 0 ? we_rd[0] : 3'bx), 32'd3);
    chk("load_imm", 32'(we_imm), 32'hBEEF);
    chk("load_imm_sel", 32'(we_isel), 32'd1);

    // ADD r4,r5 with alu_done 7 cycles after start plus a stray done in EXEC
    do_reset(); clear_prog();
    p_ins[0] = ins(3'd2, 3'd4, 3'd5); p_dly[0] = 7; p_sp[0] = 1;
    p_ins[1] = ins(3'd4, 3'd0, 3'd0);
    run_prog(100);
    chk("add_start_count", 32'(n_start), 32'd1);
    chk("add_we_cycle", 32'(we_cyc), 32'd11);
    chk("add_retired", 32'(retired), 32'd1);

    // Illegal opcode 110, then run toggling in HALT
    do_reset(); clear_prog();
    p_ins[0] = ins(3'd6, 3'd1, 3'd2);
    run_prog(100);
    repeat (6) begin @(posedge clk); #1; run = 1'($urandom_range(0, 1)); end
    chk("ill_illegal", 32'(illegal), 32'd1);
    chk("ill_done", 32'(done), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_we_count", 32'(n_we), 32'd0);
    chk("ill_step_count", 32'(n_step), 32'd0);
    chk("ill_retired", 32'(retired), 32'd0);

    // Reset during AWAIT of a slow ADD
    do_reset(); clear_prog();
    p_ins[0] = ins(3'd0, 3'd1, 3'd0); p_dat[0] = 16'h1234;
    p_ins[1] = ins(3'd2, 3'd1, 3'd1); p_dly[1] = 30;
    p_ins[2] = ins(3'd4, 3'd0, 3'd0);
    start_prog();
    for (int c = 0; c < 100 && !alu_start; c++) begin @(posedge clk); #1; end
    chk("rst_await_alu_start", 32'(alu_start), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_await_retired_before", 32'(retired), 32'd1);
    q.delete(); run = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("rst_await");
    rst_n = 1'b1;

    // Random programs; the first restarts straight from the mid-program reset
    for (int k = 0; k < 6; k++) begin
      int unsigned len;
      if (k > 0) do_reset();
      clear_prog();
      len = $urandom_range(2, 12);
      for (int unsigned i = 0; i < len; i++) begin
        p_ins[i] = ins(3'($urandom_range(0, 3)), 3'($urandom), 3'($urandom));
        p_dat[i] = 16'($urandom);
        p_dly[i] = $urandom_range(1, 6);
        p_sp[i]  = 1'($urandom_range(0, 1));
      end
      p_ins[len] = ins(($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'd4, 3'($urandom), 3'($urandom));
      run_prog(500);
    end

    // 257 MOVEs: retired wraps past 255 back to 1
    do_reset(); clear_prog();
    for (int i = 0; i < 257; i++) p_ins[i] = ins(3'd1, 3'($urandom), 3'($urandom));
    p_ins[257] = ins(3'd4, 3'd0, 3'd0);
    run_prog(3000);
    chk("wrap_retired", 32'(retired), 32'd1);

`ifdef ROM_SEQ_ALU_TIMEOUT_EN
    do_reset(); clear_prog();
    p_ins[0] = ins(3'd3, 3'd2, 3'd3); p_dly[0] = 0;
    run_prog(200);
    chk("tmo_illegal", 32'(illegal), 32'd1);
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_we_count", 32'(n_we), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
